// File: rtl/dot_feeder_pkg.sv
// Shared widths, burst geometry and FSM encoding for the dot_channel_16 feeder.
package dot_feeder_pkg;

   localparam int unsigned DATA_LEN      = 16;
   localparam int unsigned ELEMS         = 36;
   localparam int unsigned VEC_W         = ELEMS * DATA_LEN;

   localparam int unsigned BEATS_DEF     = 6;
   localparam int unsigned CS_NUM_DEF    = 16;
   localparam int unsigned PHASE_NUM_DEF = 8;

   localparam int unsigned CS_W          = 4;
   localparam int unsigned PHASE_W       = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_PREP   = 3'd2,
      ST_STREAM = 3'd3,
      ST_WAIT   = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Bits needed to hold any value 0..n-1 (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dot_feeder_beat_buffer.sv
// One-burst register file: synchronous write port, asynchronous read port.
module beat_buffer
   import dot_feeder_pkg::*;
#(
   parameter int unsigned BEATS = BEATS_DEF,
   parameter int unsigned WIDTH = VEC_W,
   parameter int unsigned IDX_W = idx_width(BEATS + 1)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wd,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WIDTH-1:0] rd_data
);

   localparam logic [IDX_W-1:0] BEATS_I = IDX_W'(BEATS);

   logic [WIDTH-1:0] mem_q [BEATS];
   logic [WIDTH-1:0] mem_d [BEATS];

   // Next contents: write the addressed slot when enabled and in range.
   always_comb begin
      mem_d = mem_q;
      if (we && (wr_idx < BEATS_I)) begin
         mem_d[wr_idx] = wd;
      end
   end

   // Storage has no reset; contents are only read after a full fill.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Out-of-range read index returns zero.
   always_comb begin
      rd_data = (rd_idx < BEATS_I) ? mem_q[rd_idx] : '0;
   end

endmodule

// File: rtl/dot_feeder.sv
// Sequencer that fills one burst, streams it to the channel and sweeps all (phase, cs) pairs.
module dot_feeder
   import dot_feeder_pkg::*;
#(
   parameter int unsigned BEATS     = BEATS_DEF,
   parameter int unsigned CS_NUM    = CS_NUM_DEF,
   parameter int unsigned PHASE_NUM = PHASE_NUM_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [VEC_W-1:0]    in_data,
   output logic                dc_load,
   output logic                ws_load,
   output logic [CS_W-1:0]     cs,
   output logic [PHASE_W-1:0]  phase,
   output logic [VEC_W-1:0]    d,
   input  logic                ch_valid,
   input  logic [DATA_LEN-1:0] ch_q,
   output logic                out_valid,
   output logic [DATA_LEN-1:0] out_q,
   output logic [CS_W-1:0]     out_cs,
   output logic [PHASE_W-1:0]  out_phase
);

   localparam int unsigned        IDX_W     = idx_width(BEATS + 1);
   localparam logic [IDX_W-1:0]   LAST_BEAT = IDX_W'(BEATS - 1);
   localparam logic [CS_W-1:0]    CS_LAST   = CS_W'(CS_NUM - 1);
   localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(PHASE_NUM - 1);

   state_e               state_q,     state_d;
   logic [IDX_W-1:0]     wr_idx_q,    wr_idx_d;
   logic [IDX_W-1:0]     rd_idx_q,    rd_idx_d;
   logic [CS_W-1:0]      cs_q,        cs_d;
   logic [PHASE_W-1:0]   phase_q,     phase_d;
   logic                 busy_q,      busy_d;
   logic                 done_q,      done_d;
   logic                 in_ready_q,  in_ready_d;
   logic                 dc_load_q,   dc_load_d;
   logic                 ws_load_q,   ws_load_d;
   logic [VEC_W-1:0]     d_q,         d_d;
   logic                 out_valid_q, out_valid_d;
   logic [DATA_LEN-1:0]  out_q_q,     out_q_d;
   logic [CS_W-1:0]      out_cs_q,    out_cs_d;
   logic [PHASE_W-1:0]   out_phase_q, out_phase_d;
   logic                 we;
   logic [VEC_W-1:0]     rd_data;

   beat_buffer #(
      .BEATS (BEATS),
      .WIDTH (VEC_W),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk     (clk),
      .we      (we),
      .wr_idx  (wr_idx_q),
      .wd      (in_data),
      .rd_idx  (rd_idx_d),
      .rd_data (rd_data)
   );

   // FSM next state, index bookkeeping and registered-output targets.
   // Outputs are decoded from state_d so they line up with the state they belong to.
   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      cs_d        = cs_q;
      phase_d     = phase_q;
      out_valid_d = 1'b0;
      out_q_d     = '0;
      out_cs_d    = '0;
      out_phase_d = '0;
      we          = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cs_d     = '0;
               phase_d  = '0;
               wr_idx_d = '0;
               state_d  = ST_FILL;
            end
         end
         ST_FILL: begin
            if (in_valid && in_ready_q) begin
               we       = 1'b1;
               wr_idx_d = wr_idx_q + 1'b1;
               if (wr_idx_q == LAST_BEAT) begin
                  state_d = ST_PREP;
               end
            end
         end
         ST_PREP: begin
            rd_idx_d = '0;
            state_d  = ST_STREAM;
         end
         ST_STREAM: begin
            rd_idx_d = rd_idx_q + 1'b1;
            if (rd_idx_q == LAST_BEAT) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ch_valid) begin
               out_valid_d = 1'b1;
               out_q_d     = ch_q;
               out_cs_d    = cs_q;
               out_phase_d = phase_q;
               wr_idx_d    = '0;
               state_d     = ST_FILL;
               if (cs_q == CS_LAST) begin
                  cs_d = '0;
                  if (phase_q == PH_LAST) begin
                     phase_d = '0;
                     state_d = ST_DONE;
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
               end else begin
                  cs_d = cs_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d = (state_d == ST_FILL);
      ws_load_d  = (state_d == ST_PREP) || (state_d == ST_STREAM);
      dc_load_d  = (state_d == ST_STREAM);
      busy_d     = (state_d != ST_IDLE);
      // done trails the DONE state so it lands one cycle after the last result.
      done_d     = (state_q == ST_DONE);
   end

   // Stream data: the slot about to be presented, zero outside STREAM.
   always_comb begin
      d_d = (state_d == ST_STREAM) ? rd_data : '0;
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         cs_q        <= '0;
         phase_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         dc_load_q   <= 1'b0;
         ws_load_q   <= 1'b0;
         d_q         <= '0;
         out_valid_q <= 1'b0;
         out_q_q     <= '0;
         out_cs_q    <= '0;
         out_phase_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         cs_q        <= cs_d;
         phase_q     <= phase_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         in_ready_q  <= in_ready_d;
         dc_load_q   <= dc_load_d;
         ws_load_q   <= ws_load_d;
         d_q         <= d_d;
         out_valid_q <= out_valid_d;
         out_q_q     <= out_q_d;
         out_cs_q    <= out_cs_d;
         out_phase_q <= out_phase_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign in_ready  = in_ready_q;
   assign dc_load   = dc_load_q;
   assign ws_load   = ws_load_q;
   assign cs        = cs_q;
   assign phase     = phase_q;
   assign d         = d_q;
   assign out_valid = out_valid_q;
   assign out_q     = out_q_q;
   assign out_cs    = out_cs_q;
   assign out_phase = out_phase_q;

endmodule
